// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Cause codes, FSM state encoding and the prioritised trap request record.
package trap_sequencer_pkg;

  localparam int TRAP_XLEN = 32;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_EBREAK  = 4'd3;
  localparam logic [3:0] EXC_ECALL_M = 4'd11;
  localparam logic [3:0] IRQ_MSI     = 4'd3;
  localparam logic [3:0] IRQ_MTI     = 4'd7;
  localparam logic [3:0] IRQ_MEI     = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SAVE,
    ST_REDIRECT,
    ST_RET
  } TRAP_SEQ_STATE;

  typedef struct packed {
    logic                 valid;
    logic                 is_irq;
    logic [3:0]           code;
    logic [TRAP_XLEN-1:0] epc;
    logic [TRAP_XLEN-1:0] tval;
  } TRAP_REQ_STRUCT;

  // mcause encoding: interrupt flag in the MSB, code in the low bits.
  function automatic logic [TRAP_XLEN-1:0] mcause_of(input TRAP_REQ_STRUCT r);
    return {r.is_irq, {(TRAP_XLEN-5){1'b0}}, r.code};
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap selector: exception first, then MEI > MSI > MTI.
// MRET is not handled here; the FSM only considers it when no trap is requested.
module trap_prio_enc
  import trap_sequencer_pkg::*;
(
  input  logic                 exc_valid,
  input  logic [3:0]           exc_cause,
  input  logic [TRAP_XLEN-1:0] exc_pc,
  input  logic [TRAP_XLEN-1:0] exc_tval,
  input  logic                 meip,
  input  logic                 mtip,
  input  logic                 msip,
  input  logic                 mie_bit,
  input  logic [TRAP_XLEN-1:0] mie_reg,
  input  logic [TRAP_XLEN-1:0] next_pc,
  output TRAP_REQ_STRUCT       req
);

  logic mei_en;
  logic mti_en;
  logic msi_en;
  logic unused_mie;

  assign mei_en = mie_bit & meip & mie_reg[11];
  assign mti_en = mie_bit & mtip & mie_reg[7];
  assign msi_en = mie_bit & msip & mie_reg[3];

  assign unused_mie = ^{mie_reg[TRAP_XLEN-1:12], mie_reg[10:8], mie_reg[6:4], mie_reg[2:0]};

  // NOTE: req is cleared before the priority chain so every path assigns it and no latch is inferred.
  always_comb begin
    req = '0;
    if (exc_valid) begin
      req.valid  = 1'b1;
      req.code   = exc_cause;
      req.epc    = exc_pc;
      req.tval   = exc_tval;
    end else if (mei_en || msi_en || mti_en) begin
      req.valid  = 1'b1;
      req.is_irq = 1'b1;
      req.epc    = next_pc;
      if (mei_en)      req.code = IRQ_MEI;
      else if (msi_en) req.code = IRQ_MSI;
      else             req.code = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: flush, CSR save, PC redirect.
// Build option VECTORED_MODE_EN: interrupts vector to base + 4*code when mtvec.MODE==1.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN         = TRAP_XLEN,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EXC_VALID,
  input  logic [3:0]      EXC_CAUSE,
  input  logic [XLEN-1:0] EXC_PC,
  input  logic [XLEN-1:0] EXC_TVAL,
  input  logic            MEIP,
  input  logic            MTIP,
  input  logic            MSIP,
  input  logic            MIE_BIT,
  input  logic [XLEN-1:0] MIE_REG,
  input  logic [XLEN-1:0] NEXT_PC,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] MEPC_IN,
  input  logic            MRET_DETECTED,
  output logic            FLUSH,
  output logic            STALL_FETCH,
  output logic            PC_REDIRECT,
  output logic [XLEN-1:0] PC_TARGET,
  output logic            CSR_TRAP_WE,
  output logic            CSR_MRET_WE,
  output logic [XLEN-1:0] MEPC_OUT,
  output logic [XLEN-1:0] MCAUSE_OUT,
  output logic [XLEN-1:0] MTVAL_OUT,
  output logic            BUSY
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  TRAP_REQ_STRUCT  req;
  TRAP_SEQ_STATE   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            irq_q, irq_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] trap_target;
  logic            flush_q, flush_d;
  logic            stall_q, stall_d;
  logic            redir_q, redir_d;
  logic            trap_we_q, trap_we_d;
  logic            mret_we_q, mret_we_d;
  logic            busy_q, busy_d;
  logic            unused_bits;

  trap_prio_enc u_prio (
    .exc_valid (EXC_VALID),
    .exc_cause (EXC_CAUSE),
    .exc_pc    (EXC_PC),
    .exc_tval  (EXC_TVAL),
    .meip      (MEIP),
    .mtip      (MTIP),
    .msip      (MSIP),
    .mie_bit   (MIE_BIT),
    .mie_reg   (MIE_REG),
    .next_pc   (NEXT_PC),
    .req       (req)
  );

`ifdef VECTORED_MODE_EN
  always_comb begin
    trap_target = {MTVEC[XLEN-1:2], 2'b00};
    if (irq_q && MTVEC[1:0] == 2'b01)
      trap_target = trap_target + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
  end
  assign unused_bits = ^MEPC_IN[1:0];
`else
  assign trap_target = {MTVEC[XLEN-1:2], 2'b00};
  assign unused_bits = ^{MEPC_IN[1:0], MTVEC[1:0], irq_q};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    irq_d    = irq_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    target_d = target_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req.valid) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          irq_d   = req.is_irq;
          cause_d = mcause_of(req);
          epc_d   = req.epc;
          tval_d  = req.tval;
        end else if (MRET_DETECTED) begin
          state_d  = ST_RET;
          target_d = {MEPC_IN[XLEN-1:2], 2'b00};
        end
      end
      ST_FLUSH: begin
        // Target is captured on the way into SAVE so it stays stable through REDIRECT.
        if (cnt_q == '0) begin
          state_d  = ST_SAVE;
          target_d = trap_target;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAVE:              state_d = ST_REDIRECT;
      ST_REDIRECT, ST_RET:  state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they align with the state they describe.
    flush_d   = 1'b0;
    stall_d   = 1'b0;
    redir_d   = 1'b0;
    trap_we_d = 1'b0;
    mret_we_d = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    unique case (state_d)
      ST_FLUSH:    begin flush_d = 1'b1; stall_d = 1'b1; end
      ST_SAVE:     begin flush_d = 1'b1; stall_d = 1'b1; trap_we_d = 1'b1; end
      ST_REDIRECT: redir_d = 1'b1;
      ST_RET:      begin flush_d = 1'b1; redir_d = 1'b1; mret_we_d = 1'b1; end
      default:     ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every flop, including the latched trap record.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      cause_q   <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      target_q  <= '0;
      flush_q   <= 1'b0;
      stall_q   <= 1'b0;
      redir_q   <= 1'b0;
      trap_we_q <= 1'b0;
      mret_we_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      target_q  <= target_d;
      flush_q   <= flush_d;
      stall_q   <= stall_d;
      redir_q   <= redir_d;
      trap_we_q <= trap_we_d;
      mret_we_q <= mret_we_d;
      busy_q    <= busy_d;
    end
  end

  assign FLUSH       = flush_q;
  assign STALL_FETCH = stall_q;
  assign PC_REDIRECT = redir_q;
  assign PC_TARGET   = target_q;
  assign CSR_TRAP_WE = trap_we_q;
  assign CSR_MRET_WE = mret_we_q;
  assign MEPC_OUT    = epc_q;
  assign MCAUSE_OUT  = cause_q;
  assign MTVAL_OUT   = tval_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: vector table plus hand-written
// priority and reset sequences; CSR/redirect results checked via a scoreboard.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  localparam int FC = 2;
`ifdef VECTORED_MODE_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        EXC_VALID, MEIP, MTIP, MSIP, MIE_BIT, MRET_DETECTED;
  logic [3:0]  EXC_CAUSE;
  logic [31:0] EXC_PC, EXC_TVAL, MIE_REG, NEXT_PC, MTVEC, MEPC_IN;
  logic        FLUSH, STALL_FETCH, PC_REDIRECT, CSR_TRAP_WE, CSR_MRET_WE, BUSY;
  logic [31:0] PC_TARGET, MEPC_OUT, MCAUSE_OUT, MTVAL_OUT;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        meip, mtip, msip, mie_bit;
    logic [31:0] mie_reg, next_pc, mtvec, mepc_in;
    logic        mret;
    int          kind;      // 0 none, 1 trap, 2 mret
    logic [31:0] e_cause, e_epc, e_tval, e_target;
  } vec_t;

  typedef struct {
    bit          is_mret;
    logic [31:0] cause, epc, tval, target;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  trap_sequencer #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .RST(RST),
    .EXC_VALID(EXC_VALID), .EXC_CAUSE(EXC_CAUSE), .EXC_PC(EXC_PC), .EXC_TVAL(EXC_TVAL),
    .MEIP(MEIP), .MTIP(MTIP), .MSIP(MSIP), .MIE_BIT(MIE_BIT), .MIE_REG(MIE_REG),
    .NEXT_PC(NEXT_PC), .MTVEC(MTVEC), .MEPC_IN(MEPC_IN), .MRET_DETECTED(MRET_DETECTED),
    .FLUSH(FLUSH), .STALL_FETCH(STALL_FETCH), .PC_REDIRECT(PC_REDIRECT), .PC_TARGET(PC_TARGET),
    .CSR_TRAP_WE(CSR_TRAP_WE), .CSR_MRET_WE(CSR_MRET_WE),
    .MEPC_OUT(MEPC_OUT), .MCAUSE_OUT(MCAUSE_OUT), .MTVAL_OUT(MTVAL_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl();
    return 32'({FLUSH, STALL_FETCH, CSR_TRAP_WE, PC_REDIRECT, CSR_MRET_WE, BUSY});
  endfunction

  task automatic clear_req(input bit keep_irq);
    EXC_VALID     = 1'b0;
    MRET_DETECTED = 1'b0;
    if (!keep_irq) begin
      MEIP = 1'b0; MTIP = 1'b0; MSIP = 1'b0;
    end
  endtask

  task automatic apply(input vec_t v);
    EXC_VALID = v.exc_valid; EXC_CAUSE = v.exc_cause; EXC_PC = v.exc_pc; EXC_TVAL = v.exc_tval;
    MEIP = v.meip; MTIP = v.mtip; MSIP = v.msip; MIE_BIT = v.mie_bit; MIE_REG = v.mie_reg;
    NEXT_PC = v.next_pc; MTVEC = v.mtvec; MEPC_IN = v.mepc_in; MRET_DETECTED = v.mret;
  endtask

  task automatic push_exp(input bit is_mret, input logic [31:0] c, e, t, tg);
    exp_t x;
    x.is_mret = is_mret; x.cause = c; x.epc = e; x.tval = t; x.target = tg;
    exp_q.push_back(x);
  endtask

  // Called at a negedge after stimulus is driven; returns at the first negedge back in IDLE.
  task automatic expect_trap(input bit keep_irq);
    @(posedge CLK); #1 clear_req(keep_irq);
    for (int i = 0; i < FC; i++) begin
      @(negedge CLK); check("flush_phase", ctl(), 32'b110001);
    end
    @(negedge CLK); check("save_phase", ctl(), 32'b111001);
    @(negedge CLK); check("redirect_phase", ctl(), 32'b000101);
    @(negedge CLK); check("trap_back_idle", ctl(), 32'b000000);
  endtask

  task automatic expect_mret();
    @(posedge CLK); #1 clear_req(1'b0);
    @(negedge CLK); check("ret_phase", ctl(), 32'b100111);
    @(negedge CLK); check("ret_back_idle", ctl(), 32'b000000);
  endtask

  task automatic expect_none();
    @(posedge CLK); #1 clear_req(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); check("no_trap_idle", ctl(), 32'b000000);
    end
  endtask

  // Scoreboard: CSR values are checked on the save strobe, the entry is retired on the redirect strobe.
  always @(negedge CLK) begin
    if (!RST) begin
      if (CSR_TRAP_WE) begin
        if (exp_q.size() == 0) check("unexpected_trap_we", 32'(CSR_TRAP_WE), 32'd0);
        else begin
          check("mcause", MCAUSE_OUT, exp_q[0].cause);
          check("mepc", MEPC_OUT, exp_q[0].epc);
          check("mtval", MTVAL_OUT, exp_q[0].tval);
          check("target_at_save", PC_TARGET, exp_q[0].target);
        end
      end
      if (PC_REDIRECT) begin
        if (exp_q.size() == 0) check("unexpected_redirect", 32'(PC_REDIRECT), 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pc_target", PC_TARGET, e.target);
          check("mret_we_on_redirect", 32'(CSR_MRET_WE), 32'(e.is_mret));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, EXC_ILLEGAL, 32'h100, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0, 32'h0, 32'h800, 32'h0, 0,
                1, 32'd2, 32'h100, 32'hFFFF_FFFF, 32'h800};
    vecs[1] = '{1'b0, 4'd0, 32'h0, 32'h0, 0, 1, 0, 1, 32'h80, 32'h204, 32'h800, 32'h0, 0,
                1, 32'h8000_0007, 32'h204, 32'h0, 32'h800};
    vecs[2] = '{1'b0, 4'd0, 32'h0, 32'h0, 0, 1, 0, 0, 32'h80, 32'h204, 32'h800, 32'h0, 0,
                0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 4'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h800, 32'h306, 1,
                2, 32'h0, 32'h0, 32'h0, 32'h304};
    vecs[4] = '{1'b1, EXC_EBREAK, 32'h2000, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h1003, 32'h0, 0,
                1, 32'd3, 32'h2000, 32'h0, 32'h1000};
    vecs[5] = '{1'b0, 4'd0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h8, 32'h40, 32'h801, 32'h0, 0,
                1, 32'h8000_0003, 32'h40, 32'h0, VEC ? 32'h80C : 32'h800};
    vecs[6] = '{1'b1, EXC_ECALL_M, 32'h44, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h801, 32'h0, 0,
                1, 32'd11, 32'h44, 32'h0, 32'h800};
    vecs[7] = '{1'b0, 4'd0, 32'h0, 32'h0, 0, 1, 1, 1, 32'h88, 32'h60, 32'h400, 32'h0, 0,
                1, 32'h8000_0003, 32'h60, 32'h0, 32'h400};
    vecs[8] = '{1'b0, 4'd0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h8, 32'h70, 32'h400, 32'h0, 0,
                0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[9] = '{1'b0, 4'd0, 32'h0, 32'h0, 1, 0, 1, 1, 32'h808, 32'h80, 32'h801, 32'h0, 0,
                1, 32'h8000_000B, 32'h80, 32'h0, VEC ? 32'h82C : 32'h800};

    RST = 1'b1;
    EXC_VALID = 0; EXC_CAUSE = 0; EXC_PC = 0; EXC_TVAL = 0; MEIP = 0; MTIP = 0; MSIP = 0;
    MIE_BIT = 0; MIE_REG = 0; NEXT_PC = 0; MTVEC = 0; MEPC_IN = 0; MRET_DETECTED = 0;
    repeat (2) @(negedge CLK);
    check("reset_ctl", ctl(), 32'd0);
    check("reset_target", PC_TARGET, 32'd0);
    check("reset_mcause", MCAUSE_OUT, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i]);
      case (vecs[i].kind)
        1: begin
          push_exp(1'b0, vecs[i].e_cause, vecs[i].e_epc, vecs[i].e_tval, vecs[i].e_target);
          expect_trap(1'b0);
        end
        2: begin
          push_exp(1'b1, 32'h0, 32'h0, 32'h0, vecs[i].e_target);
          expect_mret();
        end
        default: expect_none();
      endcase
    end

    // Exception beats interrupts and MRET; held MEIP is taken after the return to IDLE.
    EXC_VALID = 1; EXC_CAUSE = EXC_ECALL_M; EXC_PC = 32'h300; EXC_TVAL = 32'h0;
    MEIP = 1; MTIP = 1; MSIP = 0; MIE_BIT = 1; MIE_REG = 32'h880; NEXT_PC = 32'h304;
    MTVEC = 32'h800; MEPC_IN = 32'h500; MRET_DETECTED = 1;
    push_exp(1'b0, 32'd11, 32'h300, 32'h0, 32'h800);
    expect_trap(1'b1);
    push_exp(1'b0, 32'h8000_000B, 32'h304, 32'h0, 32'h800);
    expect_trap(1'b0);

    // Reset while flushing: outputs drop immediately and no CSR strobe follows.
    EXC_VALID = 1; EXC_CAUSE = EXC_ILLEGAL; EXC_PC = 32'h100; EXC_TVAL = 32'h1234; MTVEC = 32'h800;
    push_exp(1'b0, 32'd2, 32'h100, 32'h1234, 32'h800);
    @(posedge CLK); #1 clear_req(1'b0);
    @(negedge CLK); check("pre_reset_flush", ctl(), 32'b110001);
    #2 RST = 1'b1;
    #1;
    check("async_reset_ctl", ctl(), 32'd0);
    check("async_reset_mepc", MEPC_OUT, 32'd0);
    check("async_reset_mcause", MCAUSE_OUT, 32'd0);
    check("async_reset_mtval", MTVAL_OUT, 32'd0);
    exp_q.delete();
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); check("post_reset_quiet", ctl(), 32'd0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
